// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, parity modes and width helper for the UART RX/TX blocks
// Contents:
//   state_e      receiver FSM states
//   PARITY_*     parity mode constants for the PARITY parameter
//   clog2()      counter width helper (never returns less than 1)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clamped to 1 so a divide-by-1 counter still has a legal vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divide-by-CLK_DIV counter producing a 1-cycle oversample tick
// Ports:
//   sysclk   in   system clock
//   reset_n  in   asynchronous active-low reset
//   clr_i    in   synchronous clear, restarts the count at 0
//   tick_o   out  high for one cycle while the count sits at CLK_DIV-1
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 27
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int             W    = clog2(CLK_DIV);
    localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == LAST;

    always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + W'(1);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with 3-sample majority vote and valid/ready output
// Ports:
//   sysclk        in   system clock
//   reset_n       in   asynchronous active-low reset
//   rx_i          in   serial line, idle high, asynchronous to sysclk
//   rx_data_o     out  received word, held while rx_valid_o=1
//   rx_valid_o    out  word available
//   rx_ready_i    in   consumer accepts the word when rx_valid_o & rx_ready_i
//   parity_err_o  out  parity mismatch on the held word, qualified by rx_valid_o
//   frame_err_o   out  1-cycle pulse when a stop bit was sampled 0
//   overrun_o     out  1-cycle pulse when a word completed while rx_valid_o=1
//   busy_o        out  receiver not in IDLE
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 27,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int             SW        = clog2(OVS);
    localparam int             BW        = clog2(DATA_BITS);
    localparam logic [SW-1:0]  S_V0      = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0]  S_V1      = SW'(OVS / 2);
    localparam logic [SW-1:0]  S_V2      = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0]  S_LAST    = SW'(OVS - 1);
    localparam logic [BW-1:0]  B_LAST    = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);

    logic                 sync1_q, sync2_q, rxs_prev_q;
    logic                 rxs, fall, tick, clr, vote_en, bnd, vote, exp_par;
    logic                 load, ferr;
    state_e               state_q, state_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 v0_q, v1_q;
    logic                 par_err_q, par_err_d;
    logic                 stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ovr_q, ovr_d;

    assign rxs     = sync2_q;
    assign fall    = rxs_prev_q & ~rxs;
    assign vote_en = tick && scnt_q == S_V2;
    assign bnd     = tick && scnt_q == S_LAST;
    // The third sample is the live synchronised line, so the vote resolves on its own tick.
    assign vote    = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);
    assign exp_par = (PARITY == PARITY_ODD) ? ~(^shreg_q) : ^shreg_q;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .sysclk (sysclk),
        .reset_n(reset_n),
        .clr_i  (clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d    = state_q;
        scnt_d     = tick ? ((scnt_q == S_LAST) ? '0 : scnt_q + SW'(1)) : scnt_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        load       = 1'b0;
        ferr       = 1'b0;
        clr        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    scnt_d  = '0;
                    clr     = 1'b1;
                end
            end
            ST_START: begin
                if (vote_en && vote) begin
                    state_d = ST_IDLE;
                end else if (bnd) begin
                    state_d = ST_DATA;
                    bcnt_d  = '0;
                end
            end
            ST_DATA: begin
                if (vote_en) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                if (bnd) begin
                    if (bcnt_q == B_LAST) begin
                        state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        bcnt_d     = '0;
                        stop_err_d = 1'b0;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (vote_en) par_err_d = vote ^ exp_par;
                if (bnd) begin
                    state_d    = ST_STOP;
                    bcnt_d     = '0;
                    stop_err_d = 1'b0;
                end
            end
            ST_STOP: begin
                // The frame is judged on the last stop vote, with earlier stop votes folded in.
                if (vote_en && bcnt_q == STOP_LAST) begin
                    ferr    = stop_err_q | ~vote;
                    load    = ~ferr;
                    state_d = ferr ? ST_BREAK : ST_IDLE;
                end else if (vote_en) begin
                    stop_err_d = ~vote;
                end else if (bnd) begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d  = load ? shreg_q : data_q;
        perr_d  = load ? par_err_q : perr_q;
        // A load in the handshake cycle keeps the flag set; the consumer took the old word.
        valid_d = load | (valid_q & ~rx_ready_i);
        ovr_d   = load & valid_q & ~rx_ready_i;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            scnt_q     <= '0;
            bcnt_q     <= '0;
            shreg_q    <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= rx_i;
            sync2_q    <= sync1_q;
            rxs_prev_q <= sync2_q;
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            bcnt_q     <= bcnt_d;
            shreg_q    <= shreg_d;
            if (tick && scnt_q == S_V0) v0_q <= rxs;
            if (tick && scnt_q == S_V1) v1_q <= rxs;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = state_q != ST_IDLE;

endmodule
